bcd_scan_counter: RTL

BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

---
 rtl/bcd_scan_counter.sv | 103 ++++++++++
 1 files changed

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with wrap pulses and a multiplexed,
// active-low digit scan that can suppress leading zeros.
module bcd_scan_counter #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iInc,
    input  logic        iDec,
    input  logic        iClr,
    input  logic        iBlank,
    output logic [15:0] oBcd,
    output logic [3:0]  oDigit,
    output logic [3:0]  oSel,
    output logic        oOvf,
    output logic        oUnf
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    logic [15:0]   bcd_reg, bcd_next;
    logic [15:0]   bcd_inc, bcd_dec;
    logic [4:0]    carry, borrow;
    logic [3:0]    digit_zero;
    logic [3:0]    blank;
    logic          ovf_reg, ovf_next;
    logic          unf_reg, unf_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [1:0]    idx_reg, idx_next;

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    // Per-digit ripple carry/borrow; carry[4]/borrow[4] flag a full wrap.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] d;
            assign d = bcd_reg[4*gi +: 4];
            assign bcd_inc[4*gi +: 4] = carry[gi]  ? ((d == 4'd9) ? 4'd0 : d + 4'd1) : d;
            assign bcd_dec[4*gi +: 4] = borrow[gi] ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : d;
            assign carry[gi+1]   = carry[gi]  & (d == 4'd9);
            assign borrow[gi+1]  = borrow[gi] & (d == 4'd0);
            assign digit_zero[gi] = (d == 4'd0);
        end
    endgenerate

    // Units digit always shows; higher digits blank when they and all above are zero.
    assign blank[0] = 1'b0;
    generate
        for (gi = 1; gi < 4; gi++) begin : g_blank
            assign blank[gi] = iBlank & (&digit_zero[3:gi]);
        end
    endgenerate

    always_comb begin
        bcd_next = bcd_reg;
        ovf_next = 1'b0;
        unf_next = 1'b0;
        if (iClr) begin
            bcd_next = 16'h0000;
        end else if (iInc && !iDec) begin
            bcd_next = bcd_inc;
            ovf_next = carry[4];
        end else if (iDec && !iInc) begin
            bcd_next = bcd_dec;
            unf_next = borrow[4];
        end
    end

    always_comb begin
        presc_next = presc_reg + PW'(1);
        idx_next   = idx_reg;
        if (presc_reg == PRESC_LAST) begin
            presc_next = '0;
            idx_next   = idx_reg + 2'd1;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            bcd_reg   <= 16'h0000;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
            presc_reg <= '0;
            idx_reg   <= 2'd0;
        end else begin
            bcd_reg   <= bcd_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
            presc_reg <= presc_next;
            idx_reg   <= idx_next;
        end
    end

    assign oBcd   = bcd_reg;
    assign oOvf   = ovf_reg;
    assign oUnf   = unf_reg;
    assign oDigit = bcd_reg[{idx_reg, 2'b00} +: 4];
    assign oSel   = blank[idx_reg] ? 4'b1111 : ~(4'b0001 << idx_reg);

endmodule
